wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 79 +++++++
 tb/tb_wb_regfile.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 registers, two async read ports, write-back mux and a
// retired-write counter. Define WB_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module wb_regfile #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic             MemtoReg,
  input  logic [31:0]      ReadData_in,
  input  logic [31:0]      ALU_in,
  input  logic [4:0]       WriteReg_in,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  output logic [31:0]      ReadData1,
  output logic [31:0]      ReadData2,
  output logic [31:0]      WriteData,
  output logic [CNT_W-1:0] WriteCount
);

  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             wr_en;

  assign WriteData = MemtoReg ? ReadData_in : ALU_in;

  // Writes to r0 are discarded entirely, including from the counter.
  assign wr_en = reset && RegWrite && (WriteReg_in != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteReg_in] = WriteData;
    end
  end

  always_comb begin
    count_d = count_q;
    if (wr_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      count_q <= '0;
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign WriteCount = count_q;

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] data;
    data = (addr == 5'd0) ? 32'd0 : regs_q[addr];
`ifdef WB_REGFILE_BYPASS_EN
    if (wr_en && (addr == WriteReg_in)) begin
      data = WriteData;
    end
`endif
    if (!reset) begin
      data = 32'd0;
    end
    return data;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadReg1);
    ReadData2 = read_port(ReadReg2);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic against an
// array-based reference model. A second instance with CNT_W=4 exercises counter wrap.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ReadData_in;
  logic [31:0] ALU_in;
  logic [4:0]  WriteReg_in;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] rd1, rd2, wd, wc;
  logic [31:0] rd1_n, rd2_n, wd_n;
  logic [3:0]  wc_n;

  int checks = 0;
  int failures = 0;

  logic [31:0] mregs [32];
  int unsigned mcount;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ReadData_in(ReadData_in), .ALU_in(ALU_in), .WriteReg_in(WriteReg_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1), .ReadData2(rd2),
    .WriteData(wd), .WriteCount(wc)
  );

  wb_regfile #(.CNT_W(4)) dut_n (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ReadData_in(ReadData_in), .ALU_in(ALU_in), .WriteReg_in(WriteReg_in),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(rd1_n), .ReadData2(rd2_n),
    .WriteData(wd_n), .WriteCount(wc_n)
  );

  function automatic logic [31:0] exp_wd();
    return MemtoReg ? ReadData_in : ALU_in;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (RegWrite && WriteReg_in != 5'd0 && a == WriteReg_in) return exp_wd();
`endif
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 0;
  endtask

  // One rising edge; the model retires the write presented before it.
  task automatic clk_edge();
    logic        eff;
    logic [31:0] v;
    logic [4:0]  a;
    eff = reset && RegWrite && (WriteReg_in != 5'd0);
    v   = exp_wd();
    a   = WriteReg_in;
    @(posedge clk);
    if (eff) begin
      mregs[a] = v;
      mcount++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b0; ReadData_in = 32'h0BAD_0BAD;
    ALU_in = 32'hCAFE_0001; WriteReg_in = 5'd9; ReadReg1 = 5'd9; ReadReg2 = 5'd0;
    model_clear();
    #1;
    checks++;
    if (rd1 !== 32'd0) begin failures++; $display("FAIL rst_rd1 got=%h exp=0", rd1); end
    checks++;
    if (wd !== 32'hCAFE_0001) begin
      failures++; $display("FAIL rst_wd got=%h exp=cafe0001", wd);
    end
    clk_edge();
    checks++;
    if (rd1 !== 32'd0 || wc !== 32'd0) begin
      failures++; $display("FAIL rst_write_dropped rd1=%h wc=%0d exp=0/0", rd1, wc);
    end
    RegWrite = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      checks++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
        failures++; $display("FAIL rst_clear r%0d rd1=%h rd2=%h exp=0", i, rd1, rd2);
      end
    end
    checks++;
    if (wc !== 32'd0 || wc_n !== 4'd0) begin
      failures++; $display("FAIL rst_count got=%0d/%0d exp=0", wc, wc_n);
    end
  endtask

  task automatic test_alu_write();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALU_in = 32'h1234_5678; ReadData_in = $urandom;
    WriteReg_in = 5'd5; ReadReg1 = 5'd5;
    clk_edge();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h1234_5678) begin
      failures++; $display("FAIL alu_write got=%h exp=12345678", rd1);
    end
    checks++;
    if (wc !== 32'd1) begin failures++; $display("FAIL alu_count got=%0d exp=1", wc); end
  endtask

  task automatic test_zero_write();
    RegWrite = 1'b1; MemtoReg = 1'b1; ReadData_in = 32'hDEAD_BEEF; ALU_in = 32'h1;
    WriteReg_in = 5'd0; ReadReg2 = 5'd0;
    #1;
    checks++;
    if (wd !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL zero_wd got=%h exp=deadbeef", wd);
    end
    clk_edge();
    checks++;
    if (rd2 !== 32'd0) begin failures++; $display("FAIL zero_rd got=%h exp=0", rd2); end
    checks++;
    if (wc !== 32'd1) begin failures++; $display("FAIL zero_count got=%0d exp=1", wc); end
    RegWrite = 1'b0;
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    RegWrite = 1'b1; MemtoReg = 1'b0; ALU_in = 32'hA; WriteReg_in = 5'd7;
    clk_edge();
    ALU_in = 32'hB; ReadReg1 = 5'd7; ReadReg2 = 5'd7;
`ifdef WB_REGFILE_BYPASS_EN
    exp = 32'hB;
`else
    exp = 32'hA;
`endif
    #1;
    checks++;
    if (rd1 !== exp || rd2 !== exp) begin
      failures++; $display("FAIL bypass_pre rd1=%h rd2=%h exp=%h", rd1, rd2, exp);
    end
    clk_edge();
    RegWrite = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'hB) begin failures++; $display("FAIL bypass_post got=%h exp=b", rd1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RegWrite    = ($urandom_range(0, 3) != 0);
      MemtoReg    = 1'($urandom);
      ReadData_in = $urandom;
      ALU_in      = $urandom;
      WriteReg_in = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ReadReg1    = ($urandom_range(0, 3) == 0) ? WriteReg_in : 5'($urandom);
      ReadReg2    = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom);
      #1;
      checks++;
      if (wd !== exp_wd()) begin
        failures++; $display("FAIL rnd_wd n=%0d got=%h exp=%h", n, wd, exp_wd());
      end
      checks++;
      if (rd1 !== exp_rd(ReadReg1) || rd2 !== exp_rd(ReadReg2)) begin
        failures++;
        $display("FAIL rnd_rd n=%0d rd1=%h exp1=%h rd2=%h exp2=%h", n, rd1,
                 exp_rd(ReadReg1), rd2, exp_rd(ReadReg2));
      end
      clk_edge();
      checks++;
      if (wc !== mcount || wc_n !== 4'(mcount)) begin
        failures++; $display("FAIL rnd_count n=%0d got=%0d/%0d exp=%0d", n, wc, wc_n, mcount);
      end
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_count_wrap();
    reset = 1'b0;
    #1;
    model_clear();
    reset = 1'b1;
    RegWrite = 1'b1; MemtoReg = 1'b0;
    for (int n = 0; n < 17; n++) begin
      ALU_in = $urandom;
      WriteReg_in = 5'($urandom_range(1, 31));
      clk_edge();
    end
    RegWrite = 1'b0;
    #1;
    checks++;
    if (wc_n !== 4'd1) begin failures++; $display("FAIL wrap_cnt4 got=%0d exp=1", wc_n); end
    checks++;
    if (wc !== 32'd17) begin failures++; $display("FAIL wrap_cnt32 got=%0d exp=17", wc); end
  endtask

  task automatic test_reset_mid();
    RegWrite = 1'b1; MemtoReg = 1'b0; ALU_in = 32'h55; WriteReg_in = 5'd3;
    clk_edge();
    ALU_in = 32'h77; WriteReg_in = 5'd9; ReadReg1 = 5'd3; ReadReg2 = 5'd9;
    #1;
    checks++;
    if (rd1 !== 32'h55) begin failures++; $display("FAIL mid_pre got=%h exp=55", rd1); end
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0 || wc !== 32'd0) begin
      failures++; $display("FAIL mid_async rd1=%h rd2=%h wc=%0d exp=0", rd1, rd2, wc);
    end
    clk_edge();
    RegWrite = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
      failures++; $display("FAIL mid_dropped rd1=%h rd2=%h exp=0", rd1, rd2);
    end
    checks++;
    if (wc !== 32'd0 || wc_n !== 4'd0) begin
      failures++; $display("FAIL mid_count got=%0d/%0d exp=0", wc, wc_n);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_zero_write();
    test_bypass();
    test_random();
    test_count_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
